// File: rtl/byte_joining_pkg.sv
// Shared encodings and lane-width helpers for the byte-joining sequencer.
package byte_joining_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALIGN = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    LW_X1   = 2'b00,
    LW_X2   = 2'b01,
    LW_X4   = 2'b10,
    LW_RSVD = 2'b11
  } link_width_t;

  localparam int DEFAULT_NUM_LANES = 4;
  localparam int DEFAULT_SEL_W     = 2;
  localparam int DEFAULT_SKEW_MAX  = 8;

  function automatic logic [3:0] width_to_mask(input logic [1:0] lw);
    case (link_width_t'(lw))
      LW_X1:   return 4'b0001;
      LW_X2:   return 4'b0011;
      LW_X4:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] width_to_n(input logic [1:0] lw);
    case (link_width_t'(lw))
      LW_X1:   return 3'd1;
      LW_X2:   return 3'd2;
      LW_X4:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/byte_joining_ctrl_if.sv
// Lane-buffer / byte-joining mux signals seen by the sequencing controller.
interface byte_joining_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int SEL_W     = 2
) ();

  logic                 enable;
  logic [1:0]           link_width;
  logic [NUM_LANES-1:0] lane_valid;
  logic [SEL_W-1:0]     ctr_3;
  logic [NUM_LANES-1:0] lane_pop;
  logic                 out_valid;
  logic                 sop;
  logic                 skew_err;
  logic [1:0]           state;

  modport master (
    output enable, link_width, lane_valid,
    input  ctr_3, lane_pop, out_valid, sop, skew_err, state
  );

  modport slave (
    input  enable, link_width, lane_valid,
    output ctr_3, lane_pop, out_valid, sop, skew_err, state
  );

endinterface

// File: rtl/lane_sel_counter.sv
// Modulo-(last+1) lane-select counter; wrap_next tells the owner whether the
// value it is about to present is the final byte of a word.
module lane_sel_counter #(
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] count,
  output logic             wrap,
  output logic             wrap_next
);

  logic [SEL_W-1:0] count_reg;
  logic [SEL_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = wrap ? '0 : count_reg + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count     = count_reg;
  assign wrap      = (count_reg == last);
  assign wrap_next = (count_next == last);

endmodule

// File: rtl/byte_joining_ctrl.sv
// Word-alignment sequencer for the 4-lane byte-joining mux: lane select,
// word-boundary pops, stream qualification and inter-lane skew detection.
module byte_joining_ctrl
  import byte_joining_pkg::*;
#(
  parameter int NUM_LANES = DEFAULT_NUM_LANES,
  parameter int SEL_W     = DEFAULT_SEL_W,
  parameter int SKEW_MAX  = DEFAULT_SKEW_MAX
) (
  input  logic clk250k,
  input  logic reset,
  byte_joining_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(SKEW_MAX + 1);

  state_t               state_reg, state_next;
  logic [NUM_LANES-1:0] act_reg;
  logic [SEL_W-1:0]     last_reg;
  logic [CNT_W-1:0]     skew_cnt_reg, skew_cnt_next;
  logic                 skew_err_reg, skew_err_next;
  logic [NUM_LANES-1:0] lane_pop_reg;
  logic                 out_valid_reg;
  logic                 sop_reg;
  logic                 latch_act;

  logic [NUM_LANES-1:0] act_valid;
  logic                 all_valid, none_valid, partial;
  logic [NUM_LANES-1:0] mask_new;
  logic [2:0]           last_new;
  logic [SEL_W-1:0]     ctr;
  logic                 wrap, wrap_next;
  logic                 cnt_clr, cnt_en;

  // Only lanes latched as active take part in alignment decisions.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_act_valid
      assign act_valid[gi] = bus.lane_valid[gi] & act_reg[gi];
    end
  endgenerate

  assign all_valid  = (act_valid == act_reg);
  assign none_valid = (act_valid == '0);
  assign partial    = !all_valid && !none_valid;
  assign mask_new   = NUM_LANES'(width_to_mask(bus.link_width));
  assign last_new   = width_to_n(bus.link_width) - 3'd1;

  assign cnt_en  = (state_reg == ST_RUN);
  assign cnt_clr = (state_reg != ST_RUN) || (state_next != ST_RUN);

  lane_sel_counter #(
    .SEL_W(SEL_W)
  ) u_lane_sel_counter (
    .clk      (clk250k),
    .rst      (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .last     (last_reg),
    .count    (ctr),
    .wrap     (wrap),
    .wrap_next(wrap_next)
  );

  always_comb begin
    state_next    = state_reg;
    skew_cnt_next = '0;
    skew_err_next = skew_err_reg;
    latch_act     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.enable && (bus.link_width != LW_RSVD)) begin
          state_next    = ST_ALIGN;
          skew_err_next = 1'b0;
          latch_act     = 1'b1;
        end
      end
      ST_ALIGN: begin
        if (!bus.enable) begin
          state_next = ST_IDLE;
        end else if (all_valid) begin
          state_next = ST_RUN;
        end else if (partial) begin
          if (skew_cnt_reg == CNT_W'(SKEW_MAX - 1)) begin
            state_next    = ST_IDLE;
            skew_err_next = 1'b1;
          end else begin
            skew_cnt_next = skew_cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Decisions happen only at the word boundary; a word in flight always finishes.
        if (wrap) begin
          if (partial) begin
            state_next    = ST_IDLE;
            skew_err_next = 1'b1;
          end else if (!bus.enable) begin
            state_next = ST_DRAIN;
          end else if (all_valid) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_ALIGN;
          end
        end
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk250k or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      act_reg       <= '0;
      last_reg      <= '0;
      skew_cnt_reg  <= '0;
      skew_err_reg  <= 1'b0;
      lane_pop_reg  <= '0;
      out_valid_reg <= 1'b0;
      sop_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      skew_cnt_reg  <= skew_cnt_next;
      skew_err_reg  <= skew_err_next;
      if (latch_act) begin
        act_reg  <= mask_new;
        last_reg <= SEL_W'(last_new);
      end
      out_valid_reg <= (state_next == ST_RUN);
      sop_reg       <= (state_reg == ST_ALIGN) && (state_next == ST_RUN);
      lane_pop_reg  <= ((state_next == ST_RUN) && wrap_next) ? act_reg : '0;
    end
  end

  assign bus.ctr_3     = ctr;
  assign bus.lane_pop  = lane_pop_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sop       = sop_reg;
  assign bus.skew_err  = skew_err_reg;
  assign bus.state     = state_reg;

endmodule

// File: tb/tb_byte_joining_ctrl.sv
// Scenario bench for byte_joining_ctrl: expected output words are queued as
// stimulus is applied and compared one cycle later against the DUT.
module tb_byte_joining_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ALIGN = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] sb[$];

  byte_joining_ctrl_if #(.NUM_LANES(4), .SEL_W(2)) bus ();

  byte_joining_ctrl #(
    .NUM_LANES(4),
    .SEL_W    (2),
    .SKEW_MAX (8)
  ) dut (
    .clk250k(clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, ctr_3, lane_pop, out_valid, sop, skew_err}
  function automatic logic [10:0] pack_exp(input logic [1:0] st, input logic [1:0] c,
                                           input logic [3:0] p, input logic ov,
                                           input logic sp, input logic er);
    return {st, c, p, ov, sp, er};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.state, bus.ctr_3, bus.lane_pop, bus.out_valid, bus.sop, bus.skew_err};
  endfunction

  task automatic do_reset();
    bus.enable = 1'b0; bus.link_width = 2'b00; bus.lane_valid = 4'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e, o;
    rst = 1'b1;
    bus.enable = 1'b0; bus.link_width = 2'b00; bus.lane_valid = 4'h0;
    sb.push_back(pack_exp(S_IDLE, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front(); o = observed(); checks++;
    $display("reset: got=%b want=%b", o, e);
    if (o !== e) begin errors++; $display("FAIL reset got=%b want=%b", o, e); end
    rst = 1'b0;
  endtask

  task automatic test_stream(input logic [1:0] lw, input int n, input logic [3:0] mask,
                             input string name);
    logic [10:0] e, o;
    int c;
    for (int k = 0; k < 13; k++) begin
      bus.enable = 1'b1; bus.link_width = lw; bus.lane_valid = 4'hF;
      if (k == 0) begin
        sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      end else begin
        c = (k - 1) % n;
        sb.push_back(pack_exp(S_RUN, c[1:0], (c == n - 1) ? mask : 4'h0, 1'b1, k == 1, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("%s k=%0d st=%0d ctr=%0d pop=%b sop=%b", name, k, bus.state, bus.ctr_3, bus.lane_pop, bus.sop);
      if (o !== e) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", name, k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_skew_timeout();
    logic [10:0] e, o;
    for (int k = 0; k < 11; k++) begin
      bus.enable = 1'b1; bus.link_width = 2'b10;
      bus.lane_valid = (k == 0) ? 4'h0 : (k <= 9) ? 4'h7 : 4'hF;
      if (k <= 7)       sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      else if (k == 8)  sb.push_back(pack_exp(S_IDLE,  2'd0, 4'h0, 1'b0, 1'b0, 1'b1));
      else if (k == 9)  sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      else              sb.push_back(pack_exp(S_RUN,   2'd0, 4'h0, 1'b1, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("skew_timeout k=%0d st=%0d err=%b", k, bus.state, bus.skew_err);
      if (o !== e) begin errors++; $display("FAIL skew_timeout k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_skew_tolerated();
    logic [10:0] e, o;
    int c;
    for (int k = 0; k < 19; k++) begin
      bus.enable = 1'b1; bus.link_width = 2'b10;
      if (k == 0)       bus.lane_valid = 4'h0;
      else if (k <= 5)  bus.lane_valid = 4'b1011;
      else if (k <= 7)  bus.lane_valid = 4'h0;
      else if (k <= 14) bus.lane_valid = 4'b0111;
      else              bus.lane_valid = 4'hF;
      if (k <= 14) begin
        sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      end else begin
        c = k - 15;
        sb.push_back(pack_exp(S_RUN, c[1:0], (c == 3) ? 4'hF : 4'h0, 1'b1, k == 15, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("skew_ok k=%0d st=%0d ctr=%0d sop=%b err=%b", k, bus.state, bus.ctr_3, bus.sop, bus.skew_err);
      if (o !== e) begin errors++; $display("FAIL skew_ok k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_drain();
    logic [10:0] e, o;
    for (int k = 0; k < 8; k++) begin
      bus.enable = (k < 3); bus.link_width = 2'b10; bus.lane_valid = 4'hF;
      case (k)
        0:       sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
        1:       sb.push_back(pack_exp(S_RUN,   2'd0, 4'h0, 1'b1, 1'b1, 1'b0));
        2:       sb.push_back(pack_exp(S_RUN,   2'd1, 4'h0, 1'b1, 1'b0, 1'b0));
        3:       sb.push_back(pack_exp(S_RUN,   2'd2, 4'h0, 1'b1, 1'b0, 1'b0));
        4:       sb.push_back(pack_exp(S_RUN,   2'd3, 4'hF, 1'b1, 1'b0, 1'b0));
        5:       sb.push_back(pack_exp(S_DRAIN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
        default: sb.push_back(pack_exp(S_IDLE,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("drain k=%0d st=%0d ctr=%0d pop=%b ov=%b", k, bus.state, bus.ctr_3, bus.lane_pop, bus.out_valid);
      if (o !== e) begin errors++; $display("FAIL drain k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_gap();
    logic [10:0] e, o;
    logic [3:0] lv_tab [7] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3};
    for (int k = 0; k < 7; k++) begin
      bus.enable = 1'b1; bus.link_width = 2'b01; bus.lane_valid = lv_tab[k];
      case (k)
        0, 3, 4: sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
        1, 5:    sb.push_back(pack_exp(S_RUN,   2'd0, 4'h0, 1'b1, 1'b1, 1'b0));
        default: sb.push_back(pack_exp(S_RUN,   2'd1, 4'h3, 1'b1, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("gap k=%0d st=%0d ctr=%0d pop=%b sop=%b", k, bus.state, bus.ctr_3, bus.lane_pop, bus.sop);
      if (o !== e) begin errors++; $display("FAIL gap k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_wrap_priority();
    logic [10:0] e, o;
    for (int k = 0; k < 9; k++) begin
      bus.enable     = (k <= 4) || (k >= 7);
      bus.link_width = (k == 7) ? 2'b11 : 2'b10;
      bus.lane_valid = (k <= 4) ? 4'hF : (k == 5) ? 4'b0101 : 4'h0;
      case (k)
        0:          sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
        1:          sb.push_back(pack_exp(S_RUN,   2'd0, 4'h0, 1'b1, 1'b1, 1'b0));
        2:          sb.push_back(pack_exp(S_RUN,   2'd1, 4'h0, 1'b1, 1'b0, 1'b0));
        3:          sb.push_back(pack_exp(S_RUN,   2'd2, 4'h0, 1'b1, 1'b0, 1'b0));
        4:          sb.push_back(pack_exp(S_RUN,   2'd3, 4'hF, 1'b1, 1'b0, 1'b0));
        5, 6, 7:    sb.push_back(pack_exp(S_IDLE,  2'd0, 4'h0, 1'b0, 1'b0, 1'b1));
        default:    sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("wrap_prio k=%0d st=%0d err=%b", k, bus.state, bus.skew_err);
      if (o !== e) begin errors++; $display("FAIL wrap_prio k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] e, o;
    for (int k = 0; k < 4; k++) begin
      bus.enable = 1'b1; bus.link_width = 2'b10; bus.lane_valid = 4'hF;
      if (k == 0) sb.push_back(pack_exp(S_ALIGN, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      else        sb.push_back(pack_exp(S_RUN, 2'(k - 1), 4'h0, 1'b1, k == 1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("rst_mid k=%0d st=%0d ctr=%0d", k, bus.state, bus.ctr_3);
      if (o !== e) begin errors++; $display("FAIL rst_mid k=%0d got=%b want=%b", k, o, e); end
    end
    // Mid-cycle assertion: outputs must clear before any further clock edge.
    #2 rst = 1'b1;
    sb.push_back(pack_exp(S_IDLE, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front(); o = observed(); checks++;
    $display("rst_mid async st=%0d ctr=%0d", bus.state, bus.ctr_3);
    if (o !== e) begin errors++; $display("FAIL rst_async got=%b want=%b", o, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.enable = 1'b1; bus.link_width = 2'b11; bus.lane_valid = 4'hF;
      sb.push_back(pack_exp(S_IDLE, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observed(); checks++;
      $display("reserved_width k=%0d st=%0d", k, bus.state);
      if (o !== e) begin errors++; $display("FAIL reserved_width k=%0d got=%b want=%b", k, o, e); end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_stream(2'b10, 4, 4'hF, "x4");
    test_stream(2'b01, 2, 4'h3, "x2");
    test_stream(2'b00, 1, 4'h1, "x1");
    test_skew_timeout();
    test_skew_tolerated();
    test_drain();
    test_gap();
    test_wrap_priority();
    test_reset_mid_run();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_joining_ctrl.md
# byte_joining_ctrl

Sequencing controller for the byte-joining datapath on the 4-lane receive side. Decides when the four lane buffers hold a complete aligned word, drives the 2-bit lane-select `ctr_3` that steers the byte-joining mux, pops lane buffers at word boundaries and qualifies the joined byte stream. Supports x1/x2/x4 link widths and flags inter-lane skew errors.

## Interface
Parameters:
- NUM_LANES, 4, physical lane count
- SEL_W, 2, width of lane select
- SKEW_MAX, 8, max consecutive cycles of partial lane validity tolerated in ALIGN

Ports:
- clk250k  in  1  byte clock of the joined stream
- reset  in  1  asynchronous, active-high reset
- enable  in  1  controller enable
- link_width  in  2  00=x1, 01=x2, 10=x4, 11=reserved
- lane_valid  in  4  per-lane "word byte available" from lane buffers
- ctr_3  out  2  lane select to byte-joining mux
- lane_pop  out  4  per-lane consume strobe, one cycle
- out_valid  out  1  joined byte valid this cycle
- sop  out  1  first byte after (re)alignment
- skew_err  out  1  sticky skew error
- state  out  2  FSM state, debug

## Operation
- Active lanes: x1 → lane 0; x2 → lanes 0-1; x4 → lanes 0-3. N = 1/2/4. Mask `act` latched on IDLE→ALIGN; link_width ignored otherwise.
- States: IDLE(00), ALIGN(01), RUN(10), DRAIN(11).
- IDLE: all outputs 0 except skew_err (held). enable=1 and link_width≠11 → ALIGN; skew_err cleared on this transition. link_width=11 → stay IDLE.
- ALIGN: all `act` lanes valid → RUN. Some but not all valid for SKEW_MAX consecutive cycles → skew_err=1, IDLE. No lanes valid → wait indefinitely; skew counter resets. enable=0 → IDLE.
- RUN: ctr_3 counts 0..N-1, wraps to 0 (x1: stays 0). out_valid=1 every cycle. At ctr_3=N-1 (wrap cycle): lane_pop=`act`, then evaluate next word:
  - all `act` valid and enable=1 → continue RUN, ctr_3→0, no gap;
  - no `act` lane valid → ALIGN (gap; next RUN entry asserts sop);
  - partial → skew_err=1, IDLE;
  - enable=0 → DRAIN.
- enable=0 mid-word in RUN: word completes (ctr_3 reaches N-1, pop issued), then → DRAIN.
- DRAIN: one cycle, out_valid=0, lane_pop=0, → IDLE.
- lane_pop only asserted in RUN at ctr_3=N-1; never for inactive lanes.
- ctr_3 arithmetic: modulo N, 2-bit, no overflow beyond N-1.

## Timing
- All outputs registered; reset values: ctr_3=0, lane_pop=0, out_valid=0, sop=0, skew_err=0, state=IDLE.
- reset asserted at any time: outputs go to reset values immediately (asynchronous), no pop completion.
- Latency ALIGN→data: valid condition sampled in cycle k; cycle k+1 has state=RUN, ctr_3=0, out_valid=1, sop=1.
- sop high exactly one cycle (ctr_3=0 of first word after ALIGN).
- Back-to-back words: zero-cycle gap when next word is valid at wrap cycle.
- Skew timeout: skew_err rises SKEW_MAX cycles after partial validity begins; state=IDLE same edge.
- Simultaneous enable=0 and partial validity at wrap: skew_err takes priority → IDLE.

## Structure
- Package `byte_joining_pkg`: state encodings, link_width encodings, default SKEW_MAX, width→mask and width→N functions.
- Sub-module `lane_sel_counter`: mod-N counter with clear, enable and wrap flag; drives ctr_3.
- FSM, skew counter and output registers in the top module.

## Test plan
- x4, all lanes valid continuously, enable=1 → ctr_3 0,1,2,3,0…; lane_pop=1111 at every ctr_3=3; sop once; out_valid continuous.
- x2, valid continuous → ctr_3 0,1,0,1; lane_pop=0011 every 2nd cycle; lanes 2-3 never popped.
- x4, lanes 0-2 valid, lane 3 late 9 cycles (SKEW_MAX=8) → skew_err=1 after 8 cycles, state=IDLE; re-enable clears it.
- x4, lane 3 late 5 cycles → no error; RUN entered 1 cycle after lane 3 valid, sop=1, ctr_3=0.
- RUN, enable dropped at ctr_3=1 → word completes (pop at ctr_3=3), one DRAIN cycle, IDLE.
- Reset asserted at ctr_3=2 in RUN → all outputs 0 immediately, state=IDLE; link_width=11 with enable=1 → stays IDLE.
